apb_master: RTL and testbench

- APB requester that converts a simple valid/ready command stream into APB SETUP/ACCESS transfers toward the peripheral register slaves (e.g. the timer register block).
- Sits between the interrupt-handler/CPU-side sequencer and the APB peripheral bus.
- Returns a one-cycle response pulse carrying read data and the slave error status.
- Supports slaves that insert any number of wait states via pready.

---
 rtl/apb_master.sv | 178 +++++++++++++++++
 tb/tb_apb_master.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// APB requester: turns a valid/ready command stream into APB SETUP/ACCESS transfers
// and returns a one-cycle response pulse. Optional ACCESS timeout via `APB_TIMEOUT_EN.
module apb_master #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              busy,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                busy_q, busy_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_timeout_q, rsp_timeout_d;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

  // State register and registered outputs
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q       <= S_IDLE;
      cmd_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
`ifdef APB_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
`ifdef APB_TIMEOUT_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

  // Next-state and next-output logic; response fields default to 0 so they pulse for one cycle
  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = '0;
    rsp_err_d     = 1'b0;
    rsp_timeout_d = 1'b0;
`ifdef APB_TIMEOUT_EN
    cnt_d         = cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d   = S_SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_write ? cmd_wdata : '0;
`ifdef APB_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        penable_d = 1'b1;
      end
      S_ACCESS: begin
        if (pready) begin
          state_d     = S_IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
        end
`ifdef APB_TIMEOUT_EN
        // Last permitted wait cycle with pready still low: abort
        else if (cnt_q == CNT_LAST) begin
          state_d       = S_IDLE;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`else
        else begin
          state_d = S_ACCESS;
        end
`endif
      end
      default: begin
        state_d   = S_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  assign cmd_ready   = cmd_ready_q;
  assign busy        = busy_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: a scoreboard queue holds expected responses,
// popped by a response monitor on the falling edge.
module tb_apb_master;

  logic       pclk;
  logic       preset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       rsp_timeout;
  logic       busy;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;

  typedef struct packed {
    logic [7:0] rdata;
    logic       err;
    logic       tmo;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_push   = 0;
  int   n_rsp    = 0;

  apb_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT_CYCLES(16)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .busy(busy),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  // Response monitor: every pulse must match the oldest outstanding expectation
  always @(negedge pclk) begin
    if (rsp_valid === 1'b1) begin
      rsp_t e;
      n_rsp++;
      chk("rsp_outstanding", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", rsp_err, e.err);
        chk("rsp_timeout", rsp_timeout, e.tmo);
      end
    end
  end

  // One complete transfer; slave raises pready after 'waits' ACCESS cycles.
  // With hold set, cmd_valid stays high and cmd_addr keeps changing meanwhile.
  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                      input int waits, input logic [7:0] rd, input logic err, input bit hold);
    int psel_n = 0;
    int pen_n  = 0;
    int lat    = 0;
    int bad    = 0;
    rsp_t e;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    step();
    if (!hold) cmd_valid = 1'b0;
    e.rdata = wr ? 8'h00 : rd;
    e.err   = err;
    e.tmo   = 1'b0;
    exp_q.push_back(e);
    n_push++;
    chk("setup_phase", {30'd0, psel, penable}, 32'd2);
    chk("rsp_single_pulse", rsp_valid, 0);
    for (int i = 0; i < 200; i++) begin
      if (!psel) begin
        lat = i + 1;
        break;
      end
      psel_n++;
      if (penable) pen_n++;
      if (paddr !== addr || pwrite !== wr || pwdata !== (wr ? wd : 8'h00) || cmd_ready !== 1'b0)
        bad++;
      if (hold) cmd_addr = cmd_addr + 8'h01;
      if (penable && pen_n == waits + 1) begin
        pready = 1'b1; prdata = rd; pslverr = err;
      end else begin
        pready = 1'b0; prdata = 8'hEE; pslverr = 1'b0;
      end
      step();
    end
    pready  = 1'b0;
    pslverr = 1'b0;
    chk("psel_cycles", psel_n, waits + 2);
    chk("penable_cycles", pen_n, waits + 1);
    chk("held_stable", bad, 0);
    chk("latency", lat, waits + 3);
    chk("rsp_valid_at_done", rsp_valid, 1);
    chk("cmd_ready_at_done", cmd_ready, 1);
    chk("busy_at_done", busy, 0);
  endtask

  initial begin
    int pen_n;
    rsp_t e;
    preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
    prdata = 8'h00; pready = 1'b0; pslverr = 1'b0;
    step();
    step();
    preset = 1'b0;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    step();

    xfer(1'b1, 8'h00, 8'h5A, 2, 8'hFF, 1'b0, 1'b0);   // write, 2 wait states
    xfer(1'b0, 8'h00, 8'h77, 0, 8'h5A, 1'b0, 1'b0);   // read, no waits
    xfer(1'b0, 8'h07, 8'h33, 0, 8'h00, 1'b1, 1'b1);   // read error, next cmd waiting
    xfer(1'b0, 8'h10, 8'h00, 1, 8'hC3, 1'b0, 1'b1);   // accepted on rsp cycle, held valid
    xfer(1'b1, 8'h33, 8'hA5, 3, 8'hFF, 1'b1, 1'b0);   // write with slave error
    step();
    chk("idle_no_rsp", rsp_valid, 0);

    // Reset in the middle of ACCESS with pready low
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h03;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    chk("pre_reset_access", penable, 1);
    preset = 1'b1;
    step();
    chk("reset_psel", psel, 0);
    chk("reset_penable", penable, 0);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_busy", busy, 0);
    preset = 1'b0;
    step();
    chk("reset_no_late_rsp", rsp_valid, 0);

`ifdef APB_TIMEOUT_EN
    xfer(1'b0, 8'h40, 8'h00, 15, 8'h77, 1'b0, 1'b0);  // pready on the limit cycle completes
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h50;
    step();
    cmd_valid = 1'b0;
    e.rdata = 8'h00; e.err = 1'b1; e.tmo = 1'b1;
    exp_q.push_back(e);
    n_push++;
    pen_n = 0;
    for (int i = 0; i < 200; i++) begin
      if (!psel) break;
      if (penable) pen_n++;
      step();
    end
    chk("timeout_access_cycles", pen_n, 16);
    chk("timeout_psel_dropped", psel, 0);
    chk("timeout_rsp_valid", rsp_valid, 1);
    chk("timeout_flag", rsp_timeout, 1);
    chk("timeout_cmd_ready", cmd_ready, 1);
`else
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h50;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 100; i++) step();
    chk("hang_psel", psel, 1);
    chk("hang_penable", penable, 1);
    chk("hang_no_rsp", rsp_valid, 0);
    chk("hang_busy", busy, 1);
    preset = 1'b1;
    step();
    preset = 1'b0;
    chk("hang_reset_psel", psel, 0);
`endif
    step();
    step();
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("rsp_count", n_rsp, n_push);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
